// File: rtl/slam_spike_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// slam_sched_pkg
// Shared types and sizing constants for the SLAM spike scheduler front-end.
//   NCH          number of spike channels (fixed at 4, index = direction code)
//   CNT_W        pending-counter width per channel
//   REFR_CYCLES  refractory length after an accepted spike
//   LEAK_W       leak-period register / timer width
//   CNT_MAX      saturation value of a pending counter
// ---------------------------------------------------------------------------
package slam_sched_pkg;

    localparam int NCH         = 4;
    localparam int CNT_W       = 4;
    localparam int REFR_CYCLES = 15;
    localparam int LEAK_W      = 16;
    localparam int REFR_W      = $clog2(REFR_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Direction codes double as channel indices on spike_in and upd_ch.
    typedef enum logic [1:0] {
        CH_XP = 2'd0,
        CH_YP = 2'd1,
        CH_XN = 2'd2,
        CH_YN = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_LEAK  = 2'd2
    } state_e;

    // Round-robin successor of a granted channel (wraps 3 -> 0).
    function automatic logic [1:0] next_ptr(input logic [1:0] sel);
        return sel + 2'd1;
    endfunction

endpackage

// File: rtl/slam_spike_scheduler_if.sv
// ---------------------------------------------------------------------------
// slam_spike_scheduler_if
// Valid/ready update port from the spike scheduler to the membrane datapath.
//   upd_valid  scheduler -> integrator  update request
//   upd_ready  integrator -> scheduler  update accepted
//   upd_ch     scheduler -> integrator  direction code (0 for leak ticks)
//   upd_leak   scheduler -> integrator  1 = leak tick, 0 = spike
// Modports: master (scheduler side), slave (integrator side).
// ---------------------------------------------------------------------------
interface slam_spike_scheduler_if;
    import slam_sched_pkg::*;

    logic       upd_valid;
    logic       upd_ready;
    dir_e       upd_ch;
    logic       upd_leak;

    modport master (
        output upd_valid,
        output upd_ch,
        output upd_leak,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_ch,
        input  upd_leak,
        output upd_ready
    );

endinterface

// File: rtl/slam_spike_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// slam_rr_arbiter
// Combinational 4-way round-robin picker. Searches req_i starting at ptr_i
// and wrapping; returns the first requesting index.
//   req_i      [3:0] per-channel request
//   ptr_i      [1:0] highest-priority index this round
//   gnt_idx_o  [1:0] selected index (ptr_i when nothing requests)
//   any_o            at least one request present
// ---------------------------------------------------------------------------
module slam_rr_arbiter (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [1:0] gnt_idx_o,
    output logic       any_o
);

    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] offset;

    // Rotate so that bit 0 is the channel at ptr_i; a fixed priority
    // encoder on the rotated vector then gives round-robin order.
    assign req_dbl = {req_i, req_i} >> ptr_i;
    assign req_rot = req_dbl[3:0];

    always_comb begin
        offset = 2'd0;
        if      (req_rot[0]) offset = 2'd0;
        else if (req_rot[1]) offset = 2'd1;
        else if (req_rot[2]) offset = 2'd2;
        else if (req_rot[3]) offset = 2'd3;
    end

    assign gnt_idx_o = ptr_i + offset;
    assign any_o     = |req_i;

endmodule

// File: rtl/slam_spike_scheduler.sv
// ---------------------------------------------------------------------------
// slam_spike_scheduler
// Front-end scheduler for the neuromorphic odometry integrator. Edge-detects
// four direction spike lines, applies per-channel refractory filtering,
// queues accepted spikes in saturating counters and serialises them, plus
// periodic leak ticks, onto a single valid/ready update port.
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active-high
//   en            scheduler enable
//   spike_in[3:0] synchronised spike lines: [0]+X [1]+Y [2]-X [3]-Y
//   leak_period   cycles between leak ticks; 0 disables leak
//   upd           update port (master modport of slam_spike_scheduler_if)
//   busy          pending work or a transaction in flight
//   overflow_irq  sticky: a spike was dropped on a saturated counter
//   irq_clr       clears overflow_irq (and drop_count when present)
//   drop_count    [15:0] saturating count of discarded edges
//                 (only when SPIKE_DROP_CNT_EN is defined)
//
// Optional feature macro: SPIKE_DROP_CNT_EN
// ---------------------------------------------------------------------------
module slam_spike_scheduler
    import slam_sched_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NCH-1:0]            spike_in,
    input  logic [LEAK_W-1:0]         leak_period,
    slam_spike_scheduler_if.master    upd,
    output logic                      busy,
    output logic                      overflow_irq,
    input  logic                      irq_clr
`ifdef SPIKE_DROP_CNT_EN
    ,
    output logic [15:0]               drop_count
`endif
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NCH-1:0]    prev_spike_q;
    logic [CNT_W-1:0]  pending_q [NCH];
    logic [CNT_W-1:0]  pending_d [NCH];
    logic [REFR_W-1:0] refr_q    [NCH];
    logic [REFR_W-1:0] refr_d    [NCH];
    logic [LEAK_W-1:0] leak_cnt_q, leak_cnt_d;
    logic              leak_pend_q, leak_pend_d;
    state_e            state_q, state_d;
    dir_e              sel_q, sel_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic              ovf_q, ovf_d;

    // ------------------------------------------------------------------
    // Per-channel combinational signals
    // ------------------------------------------------------------------
    logic [NCH-1:0] rise;
    logic [NCH-1:0] accept;
    logic [NCH-1:0] sat;
    logic [NCH-1:0] inc;
    logic [NCH-1:0] dec;
    logic [NCH-1:0] req;
    logic           grant_hs;
    logic           leak_hs;
    logic           leak_fire;
    logic [1:0]     arb_idx;
    logic           arb_any;

    assign grant_hs = (state_q == S_GRANT) && upd.upd_ready;
    assign leak_hs  = (state_q == S_LEAK)  && upd.upd_ready;

    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment so the block cannot infer a latch.
        rise   = spike_in & ~prev_spike_q;
        accept = '0;
        sat    = '0;
        inc    = '0;
        dec    = '0;
        req    = '0;
        for (int i = 0; i < NCH; i++) begin
            pending_d[i] = pending_q[i];
            refr_d[i]    = refr_q[i];

            accept[i] = rise[i] && en && (refr_q[i] == '0);
            sat[i]    = (pending_q[i] == CNT_MAX);
            inc[i]    = accept[i] && !sat[i];
            dec[i]    = grant_hs && (sel_q == dir_e'(i));
            req[i]    = (pending_q[i] != '0);

            // Increment and decrement in the same cycle cancel out.
            if (inc[i] && !dec[i]) begin
                pending_d[i] = pending_q[i] + CNT_W'(1);
            end else if (dec[i] && !inc[i]) begin
                pending_d[i] = pending_q[i] - CNT_W'(1);
            end

            // Refractory countdown runs regardless of en.
            if (accept[i]) begin
                refr_d[i] = REFR_W'(REFR_CYCLES);
            end else if (refr_q[i] != '0) begin
                refr_d[i] = refr_q[i] - REFR_W'(1);
            end
        end
    end

    // Sticky overflow: a same-cycle set beats irq_clr.
    always_comb begin
        ovf_d = ovf_q;
        if (|(accept & sat)) begin
            ovf_d = 1'b1;
        end else if (irq_clr) begin
            ovf_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Leak timer
    // ------------------------------------------------------------------
    always_comb begin
        leak_cnt_d = leak_cnt_q;
        leak_fire  = 1'b0;
        if (!en || (leak_period == '0)) begin
            leak_cnt_d = '0;
        end else if (leak_cnt_q >= leak_period - LEAK_W'(1)) begin
            // >= rather than == so a period shortened mid-count wraps at
            // once instead of running the timer all the way round.
            leak_cnt_d = '0;
            leak_fire  = 1'b1;
        end else begin
            leak_cnt_d = leak_cnt_q + LEAK_W'(1);
        end

        // A timeout in the handshake cycle keeps the tick pending.
        leak_pend_d = leak_pend_q;
        if (leak_fire) begin
            leak_pend_d = 1'b1;
        end else if (leak_hs) begin
            leak_pend_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Arbiter and FSM
    // ------------------------------------------------------------------
    slam_rr_arbiter u_arb (
        .req_i     (req),
        .ptr_i     (rr_ptr_q),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        rr_ptr_d       = rr_ptr_q;
        upd.upd_valid  = 1'b0;
        upd.upd_ch     = CH_XP;
        upd.upd_leak   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    if (leak_pend_q) begin
                        state_d = S_LEAK;
                    end else if (arb_any) begin
                        sel_d   = dir_e'(arb_idx);
                        state_d = S_GRANT;
                    end
                end
            end
            S_GRANT: begin
                // Request stays up even if en drops; only a handshake ends it.
                upd.upd_valid = 1'b1;
                upd.upd_ch    = sel_q;
                if (upd.upd_ready) begin
                    rr_ptr_d = next_ptr(sel_q);
                    state_d  = S_IDLE;
                end
            end
            S_LEAK: begin
                upd.upd_valid = 1'b1;
                upd.upd_leak  = 1'b1;
                if (upd.upd_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of its inputs.
        prev_spike_q <= spike_in;
        if (rst) begin
            // NOTE: the per-channel counter arrays are reset explicitly;
            // queued spikes and refractory windows must not survive reset.
            for (int i = 0; i < NCH; i++) begin
                pending_q[i] <= '0;
                refr_q[i]    <= '0;
            end
            prev_spike_q <= '0;
            leak_cnt_q   <= '0;
            leak_pend_q  <= 1'b0;
            state_q      <= S_IDLE;
            sel_q        <= CH_XP;
            rr_ptr_q     <= 2'd0;
            ovf_q        <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                pending_q[i] <= pending_d[i];
                refr_q[i]    <= refr_d[i];
            end
            leak_cnt_q  <= leak_cnt_d;
            leak_pend_q <= leak_pend_d;
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy         = (|req) || leak_pend_q || (state_q != S_IDLE);
    assign overflow_irq = ovf_q;

`ifdef SPIKE_DROP_CNT_EN
    // ------------------------------------------------------------------
    // Discarded-edge counter: refractory, disabled, or saturated.
    // ------------------------------------------------------------------
    logic [NCH-1:0] discard;
    logic [2:0]     n_drop;
    logic [16:0]    drop_sum;
    logic [15:0]    drop_q, drop_d;

    always_comb begin
        discard  = (rise & ~accept) | (accept & sat);
        n_drop   = 3'($countones(discard));
        drop_sum = {1'b0, drop_q} + 17'(n_drop);
        drop_d   = drop_q;
        // A same-cycle increment beats irq_clr.
        if (n_drop != 3'd0) begin
            drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end else if (irq_clr) begin
            drop_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= 16'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`endif

endmodule
